// File: rtl/regfile_scoreboard.sv
// Y86-64 register file: two combinational read ports, two write-back ports,
// write-to-read bypass and a per-register pending-write scoreboard.
// The scoreboard lets decode detect RAW hazards and stall.
module regfile_scoreboard #(
  parameter int                 DATA_WID   = 64,
  parameter int                 ADDR_WID   = 4,
  parameter int                 NUM_OF_REG = 15,
  parameter int                 RNONE      = 15,
  parameter int                 RSP_IDX    = 4,
  parameter logic [DATA_WID-1:0] RSP_INIT  = DATA_WID'(64),
  parameter int                 PEND_W     = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [ADDR_WID-1:0] srcA,
  input  logic [ADDR_WID-1:0] srcB,
  output logic [DATA_WID-1:0] valA,
  output logic [DATA_WID-1:0] valB,
  output logic                busyA,
  output logic                busyB,
  input  logic [ADDR_WID-1:0] destE,
  input  logic [DATA_WID-1:0] valE,
  input  logic [ADDR_WID-1:0] destM,
  input  logic [DATA_WID-1:0] valM,
  input  logic                issue_valid,
  input  logic [ADDR_WID-1:0] issue_dstE,
  input  logic [ADDR_WID-1:0] issue_dstM,
  output logic                issue_ready
);

  // Counter arithmetic is done two bits wider and signed so that
  // cnt + inc - dec can be checked for both overflow and underflow.
  localparam int CW = PEND_W + 2;
  localparam logic signed [CW-1:0]       CMAX   = CW'((1 << PEND_W) - 1);
  localparam logic [ADDR_WID-1:0]        NREG_A = ADDR_WID'(NUM_OF_REG);
  localparam logic [ADDR_WID-1:0]        NONE_A = ADDR_WID'(RNONE);

  logic [DATA_WID-1:0]   r_reg [NUM_OF_REG];
  logic [PEND_W-1:0]     r_cnt [NUM_OF_REG];

  logic                  w_we_e;
  logic                  w_we_m;
  logic                  w_ovf;
  logic                  w_accept;
  logic [NUM_OF_REG-1:0] w_busy_reg;
  logic signed [CW-1:0]  w_after_dec [NUM_OF_REG];
  logic signed [CW-1:0]  w_need      [NUM_OF_REG];
  logic [PEND_W-1:0]     w_cnt_nxt   [NUM_OF_REG];

  // Number of the two indices (0..2) that name register r.
  function automatic logic [1:0] count_hits(input logic [ADDR_WID-1:0] a,
                                            input logic [ADDR_WID-1:0] b,
                                            input logic [ADDR_WID-1:0] r);
    count_hits = {1'b0, (a == r)} + {1'b0, (b == r)};
  endfunction

  function automatic logic signed [CW-1:0] ext_hits(input logic [1:0] h);
    ext_hits = $signed({{(CW-2){1'b0}}, h});
  endfunction

  function automatic logic signed [CW-1:0] ext_cnt(input logic [PEND_W-1:0] c);
    ext_cnt = $signed({2'b00, c});
  endfunction

  // A negative net result is a write-back with nothing pending: hold at zero.
  function automatic logic [PEND_W-1:0] clamp_cnt(input logic signed [CW-1:0] v);
    clamp_cnt = v[CW-1] ? '0 : v[PEND_W-1:0];
  endfunction

  assign w_we_e = (destE != NONE_A) && (destE < NREG_A);
  assign w_we_m = (destM != NONE_A) && (destM < NREG_A);

  // Per-register scoreboard view: pending after this cycle's write-backs,
  // projected count if the offered issue were taken, and overflow detection.
  always_comb begin
    w_ovf = 1'b0;
    for (int i = 0; i < NUM_OF_REG; i++) begin
      w_after_dec[i] = ext_cnt(r_cnt[i]) - ext_hits(count_hits(destE, destM, ADDR_WID'(i)));
      w_need[i]      = w_after_dec[i] + ext_hits(count_hits(issue_dstE, issue_dstM, ADDR_WID'(i)));
      w_busy_reg[i]  = !w_after_dec[i][CW-1] && (w_after_dec[i] != '0);
      if (w_need[i] > CMAX) w_ovf = 1'b1;
    end
  end

  assign issue_ready = !w_ovf;
  assign w_accept    = issue_valid && !w_ovf;

  // Next counter value: the issue increment only counts when accepted.
  always_comb begin
    for (int i = 0; i < NUM_OF_REG; i++) begin
      w_cnt_nxt[i] = w_accept ? clamp_cnt(w_need[i]) : clamp_cnt(w_after_dec[i]);
    end
  end

  // Read port A: stored data, overridden by same-cycle write-back (M beats E).
  always_comb begin
    valA  = '0;
    busyA = 1'b0;
    for (int i = 0; i < NUM_OF_REG; i++) begin
      if (srcA == ADDR_WID'(i)) begin
        valA  = r_reg[i];
        busyA = w_busy_reg[i];
      end
    end
    if (srcA < NREG_A) begin
      if (srcA == destM)      valA = valM;
      else if (srcA == destE) valA = valE;
    end
  end

  // Read port B: identical to port A.
  always_comb begin
    valB  = '0;
    busyB = 1'b0;
    for (int i = 0; i < NUM_OF_REG; i++) begin
      if (srcB == ADDR_WID'(i)) begin
        valB  = r_reg[i];
        busyB = w_busy_reg[i];
      end
    end
    if (srcB < NREG_A) begin
      if (srcB == destM)      valB = valM;
      else if (srcB == destE) valB = valE;
    end
  end

  // Register and counter update; M is assigned last so it wins a tie with E.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_OF_REG; i++) begin
        r_reg[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OF_REG; i++) begin
        if (w_we_e && (destE == ADDR_WID'(i))) r_reg[i] <= valE;
        if (w_we_m && (destM == ADDR_WID'(i))) r_reg[i] <= valM;
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a driver applies stimulus and
// pushes the reference model's expected outputs; a monitor pops and compares.
module tb_regfile_scoreboard;

  localparam int NREG = 15;
  localparam int NONE = 15;
  localparam int PMAX = 3;

  logic        CLK;
  logic        RST;
  logic [3:0]  srcA, srcB, destE, destM, issue_dstE, issue_dstM;
  logic [63:0] valA, valB, valE, valM;
  logic        busyA, busyB, issue_valid, issue_ready;

  regfile_scoreboard dut (
    .CLK(CLK), .RST(RST),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .busyA(busyA), .busyB(busyB),
    .destE(destE), .valE(valE), .destM(destM), .valM(valM),
    .issue_valid(issue_valid), .issue_dstE(issue_dstE),
    .issue_dstM(issue_dstM), .issue_ready(issue_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          step;
    logic [63:0] a;
    logic [63:0] b;
    logic        ba;
    logic        bb;
    logic        rdy;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          step     = 0;

  // Reference model: architectural contents and outstanding-write counts.
  logic [63:0] m_reg [NREG];
  int          m_cnt [NREG];

  function automatic int hits(input int x, input int y, input int r);
    return ((x == r) ? 1 : 0) + ((y == r) ? 1 : 0);
  endfunction

  function automatic logic [63:0] m_read(input int s, input int dE, input logic [63:0] vE,
                                         input int dM, input logic [63:0] vM);
    if (s >= NREG) return 64'd0;
    if (s == dM)   return vM;
    if (s == dE)   return vE;
    return m_reg[s];
  endfunction

  function automatic logic m_busy(input int s, input int dE, input int dM);
    if (s >= NREG) return 1'b0;
    return (m_cnt[s] - hits(dE, dM, s)) > 0;
  endfunction

  task automatic chk(input string nm, input int stp, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, stp, act, req);
    end
  endtask

  task automatic drive(input bit rst, input int sA, input int sB,
                       input int dE, input logic [63:0] vE,
                       input int dM, input logic [63:0] vM,
                       input bit iv, input int iE, input int iM);
    exp_t e;
    bit   rdy;
    bit   acc;
    int   n;
    @(posedge CLK);
    #1;
    RST         = rst;
    srcA        = 4'(sA);
    srcB        = 4'(sB);
    destE       = 4'(dE);
    valE        = vE;
    destM       = 4'(dM);
    valM        = vM;
    issue_valid = iv;
    issue_dstE  = 4'(iE);
    issue_dstM  = 4'(iM);
    step++;
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_reg[r] = (r == 4) ? 64'd64 : 64'd0;
        m_cnt[r] = 0;
      end
    end else begin
      rdy = 1'b1;
      for (int r = 0; r < NREG; r++)
        if (hits(iE, iM, r) > 0 && m_cnt[r] + hits(iE, iM, r) - hits(dE, dM, r) > PMAX)
          rdy = 1'b0;
      e.step = step;
      e.a    = m_read(sA, dE, vE, dM, vM);
      e.b    = m_read(sB, dE, vE, dM, vM);
      e.ba   = m_busy(sA, dE, dM);
      e.bb   = m_busy(sB, dE, dM);
      e.rdy  = rdy;
      q.push_back(e);
      acc = iv && rdy;
      for (int r = 0; r < NREG; r++) begin
        n = m_cnt[r] + (acc ? hits(iE, iM, r) : 0) - hits(dE, dM, r);
        m_cnt[r] = (n < 0) ? 0 : n;
      end
      if (dE < NREG) m_reg[dE] = vE;
      if (dM < NREG) m_reg[dM] = vM;
    end
  endtask

  // Monitor: outputs are combinational, so each driven cycle's response is
  // sampled on the falling edge of that cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("valA",        e.step, valA,                  e.a);
      chk("valB",        e.step, valB,                  e.b);
      chk("busyA",       e.step, {63'd0, busyA},        {63'd0, e.ba});
      chk("busyB",       e.step, {63'd0, busyB},        {63'd0, e.bb});
      chk("issue_ready", e.step, {63'd0, issue_ready},  {63'd0, e.rdy});
    end
  end

  function automatic int pick_reg();
    int k;
    k = $urandom_range(0, 7);
    if (k < 5)  return k;
    if (k == 5) return $urandom_range(0, 15);
    return NONE;
  endfunction

  initial begin
    RST = 1'b1; srcA = '0; srcB = '0; destE = 4'(NONE); destM = 4'(NONE);
    valE = '0; valM = '0; issue_valid = 1'b0;
    issue_dstE = 4'(NONE); issue_dstM = 4'(NONE);

    // Reset, then read stack pointer and r0
    drive(1, 0, 0, NONE, 0, NONE, 0, 0, NONE, NONE);
    drive(0, 4, 0, NONE, 0, NONE, 0, 0, NONE, NONE);
    // Write / read, no-write encoding
    drive(0, 3, 0, 3, 64'h1234, NONE, 0, 0, NONE, NONE);
    drive(0, 3, 0, NONE, 0, NONE, 0, 0, NONE, NONE);
    drive(0, 15, 3, 15, 64'hdead, NONE, 0, 0, NONE, NONE);
    // E/M priority and bypass
    drive(0, 4, 0, 4, 64'hAA, 4, 64'hBB, 0, NONE, NONE);
    drive(0, 4, 0, NONE, 0, NONE, 0, 0, NONE, NONE);
    // Scoreboard issue then write-back
    drive(0, 2, 0, NONE, 0, NONE, 0, 1, 2, NONE);
    drive(0, 2, 0, NONE, 0, NONE, 0, 0, NONE, NONE);
    drive(0, 2, 0, 2, 64'd7, NONE, 0, 0, NONE, NONE);
    drive(0, 2, 0, NONE, 0, NONE, 0, 0, NONE, NONE);
    // Saturation of reg 5
    repeat (3) drive(0, 5, 2, NONE, 0, NONE, 0, 1, 5, NONE);
    drive(0, 5, 0, NONE, 0, NONE, 0, 1, 5, NONE);
    drive(0, 5, 0, NONE, 0, 5, 64'd9, 1, 5, NONE);
    drive(0, 5, 0, NONE, 0, NONE, 0, 1, 5, NONE);
    // Reset mid-flight
    drive(0, 1, 0, NONE, 0, NONE, 0, 1, 1, NONE);
    drive(1, 1, 0, 1, 64'h55, NONE, 0, 1, 1, NONE);
    drive(0, 1, 4, NONE, 0, NONE, 0, 0, NONE, NONE);
    drive(0, 5, 2, NONE, 0, NONE, 0, 0, NONE, NONE);

    // Randomized traffic concentrated on a few registers to reach saturation
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) == 0), $urandom_range(0, 15), $urandom_range(0, 15),
            pick_reg(), {$urandom, $urandom}, pick_reg(), {$urandom, $urandom},
            $urandom_range(0, 1), pick_reg(), pick_reg());
    end

    @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised Y86-64 register file with two combinational read ports (A, B) and two synchronous write ports (E, M).
- Adds three behaviours to the base register file:
  - synchronous reset with a programmable stack-pointer init;
  - write-to-read bypass;
  - a per-register pending-write scoreboard, so the decode stage can detect RAW hazards and stall.
- Sits between decode (reads, issue) and write-back (E/M writes).

Parameters:
- DATA_WID, 64, register data width in bits.
- ADDR_WID, 4, register index width.
- NUM_OF_REG, 15, number of architectural registers (indices 0..NUM_OF_REG-1).
- RNONE, 15, "no register" index; must be >= NUM_OF_REG.
- RSP_IDX, 4, stack pointer index.
- RSP_INIT, 64, reset value of the stack pointer.
- PEND_W, 2, width of each per-register pending counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- srcA  in  ADDR_WID  read index, port A.
- srcB  in  ADDR_WID  read index, port B.
- valA  out  DATA_WID  read data, port A (combinational).
- valB  out  DATA_WID  read data, port B (combinational).
- busyA  out  1  srcA has an outstanding write not yet visible.
- busyB  out  1  srcB has an outstanding write not yet visible.
- destE  in  ADDR_WID  write index, port E; RNONE means no write.
- valE  in  DATA_WID  write data, port E.
- destM  in  ADDR_WID  write index, port M; RNONE means no write.
- valM  in  DATA_WID  write data, port M.
- issue_valid  in  1  decode issues an instruction.
- issue_dstE  in  ADDR_WID  future E destination (RNONE = none).
- issue_dstM  in  ADDR_WID  future M destination (RNONE = none).
- issue_ready  out  1  issue accepted this cycle.

Behaviour:
- Clocking and reset:
  - Single clock CLK.
  - Reset RST is synchronous and active-high.
  - On a posedge with RST=1: every register is cleared to 0, except register RSP_IDX, which is set to RSP_INIT. All pending counters are cleared to 0.
  - RST overrides any same-cycle write or issue.
  - After reset: busyA=busyB=0 and issue_ready=1; valA and valB reflect the reset contents.
- Writes (posedge, RST=0):
  - Port E writes valE to destE if destE < NUM_OF_REG; port M does the same with valM/destM.
  - If destE == destM and the index is valid, valM wins (popq %rsp semantics).
  - Any index >= NUM_OF_REG (including RNONE) causes no write.
- Reads (combinational), applied per port (A shown; B identical):
  - If srcA >= NUM_OF_REG, valA = 0.
  - Else if srcA == destM, valA = valM.
  - Else if srcA == destE, valA = valE.
  - Else valA = stored data.
  - The bypass makes write-back data visible in the same cycle it is presented.
- Scoreboard: one PEND_W-bit counter per register.
  - inc(r) = number of issue_dstE/issue_dstM equal to r, counted only on an accepted issue.
  - dec(r) = number of destE/destM equal to r.
  - Each posedge: cnt(r) <= cnt(r) + inc(r) - dec(r).
  - Simultaneous issue and write-back to the same register net out; e.g. inc 1 and dec 1 leaves cnt unchanged.
  - A write-back when cnt(r) == 0 (the "decrement-at-zero" case) is an unscoreboarded write: the data is still written and cnt stays 0 (no underflow).
- Busy flags:
  - busyA = (srcA < NUM_OF_REG) && (cnt(srcA) - dec(srcA) > 0).
  - A write arriving this cycle therefore clears busy combinationally, consistent with the bypass.
  - busyB is defined the same way on srcB.
- Issue handshake:
  - issue_ready = 0 if, for any valid issue destination r, cnt(r) + inc(r) - dec(r) would exceed 2^PEND_W - 1.
  - Otherwise issue_ready = 1.
  - Issue is accepted when issue_valid && issue_ready.
  - A rejected issue changes no counter; the issuer holds its inputs and retries.
  - issue_ready is independent of issue_valid.
- No state changes other than those listed above.

Test Plan:
- Reset: assert RST for 1 cycle, then srcA=4, srcB=0 -> valA=64, valB=0, busyA=busyB=0, issue_ready=1.
- Write/read and no-write encoding: destE=3, valE=0x1234 for 1 cycle, then destE=RNONE; srcA=3 -> valA=0x1234. Write with destE=15 -> no register changes; srcA=15 -> valA=0.
- Priority and bypass:
  - destE=destM=4, valE=0xAA, valM=0xBB -> next cycle valA(src 4)=0xBB.
  - Same cycle with srcA=4 -> valA=0xBB combinationally.
- Scoreboard:
  - Issue issue_dstE=2 -> busyA(src 2)=1 from the next cycle.
  - Write-back destE=2, valE=7 -> busyA=0 and valA=7 in the same cycle; counter is 0 afterwards.
- Saturation (PEND_W=2):
  - Issue dstE=5 three times -> issue_ready=0 for a fourth issue to reg 5.
  - Same cycle with destM=5 -> issue_ready=1; the issue is accepted and the counter stays at 3.
- Reset mid-flight: counters nonzero and a write to reg 1 presented while RST=1 -> all busy flags 0, reg 1=0, reg 4=64 afterwards.
